sigma_delta_dac: RTL



---
 rtl/sigma_delta_pkg.sv | 41 ++++
 rtl/sigma_delta_dac_modulator.sv | 65 ++++++
 rtl/sigma_delta_dac.sv | 66 ++++++
 3 files changed

// File: rtl/sigma_delta_pkg.sv
// Shared types and arithmetic helpers for the sigma-delta converter family.
package sigma_delta_pkg;

  typedef enum logic {
    MOD_FIRST  = 1'b0,
    MOD_SECOND = 1'b1
  } mod_order_e;

  function automatic int i1_width(input int dac_bitlen);
    return dac_bitlen + 3;
  endfunction

  function automatic int i2_width(input int dac_bitlen);
    return dac_bitlen + 5;
  endfunction

  // Stable second-order input range: [2^N/16, 15*2^N/16]
  function automatic logic [63:0] stable_lo(input int dac_bitlen);
    return 64'd1 << (dac_bitlen - 4);
  endfunction

  function automatic logic [63:0] stable_hi(input int dac_bitlen);
    return 64'd15 << (dac_bitlen - 4);
  endfunction

  // Add in 64-bit signed, then clamp to the range of a signed 'width'-bit value.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/sigma_delta_dac_modulator.sv
// Delta-sigma modulator core: turns the held sample cur into a 1-bit stream.
module sigma_delta_dac_modulator
  import sigma_delta_pkg::*;
#(
  parameter int DAC_BITLEN = 24,
  parameter int MOD_ORDER  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAC_BITLEN-1:0] cur,
  output logic                  dac_pin
);

  localparam mod_order_e ORDER = (MOD_ORDER == 2) ? MOD_SECOND : MOD_FIRST;

  generate
    if (ORDER == MOD_FIRST) begin : g_first
      logic [DAC_BITLEN-1:0] acc;
      logic [DAC_BITLEN:0]   sum;

      assign sum = {1'b0, acc} + {1'b0, cur};

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc     <= '0;
          dac_pin <= 1'b0;
        end else begin
          dac_pin <= sum[DAC_BITLEN];
          acc     <= sum[DAC_BITLEN-1:0];
        end
      end
    end else begin : g_second
      localparam int W1 = i1_width(DAC_BITLEN);
      localparam int W2 = i2_width(DAC_BITLEN);

      logic signed [W1-1:0] i1;
      logic signed [W1-1:0] i1_next;
      logic signed [W2-1:0] i2;
      logic signed [W2-1:0] i2_next;
      logic signed [63:0]   fb;
      logic signed [63:0]   cur_w;

      // Integrators clamp instead of wrapping so out-of-range inputs stay bounded.
      always_comb begin
        fb      = dac_pin ? (64'sd1 <<< DAC_BITLEN) : 64'sd0;
        cur_w   = $signed({{(64-DAC_BITLEN){1'b0}}, cur});
        i1_next = W1'(sat_add(64'(i1), cur_w - fb, W1));
        i2_next = W2'(sat_add(64'(i2), 64'(i1_next) - fb, W2));
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          i1      <= '0;
          i2      <= '0;
          dac_pin <= 1'b0;
        end else begin
          i1      <= i1_next;
          i2      <= i2_next;
          dac_pin <= (i2_next >= 0);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sigma_delta_dac.sv
// Sigma-delta DAC top: sample handshake, one-entry hold register, oversample tick.
module sigma_delta_dac
  import sigma_delta_pkg::*;
#(
  parameter int DAC_BITLEN      = 24,
  parameter int OVERSAMPLE_RATE = 256,
  parameter int MOD_ORDER       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAC_BITLEN-1:0] dac_input,
  input  logic                  dac_valid,
  output logic                  dac_ready,
  output logic                  dac_pin,
  output logic                  dac_underrun,
  output logic                  sample_tick
);

  localparam int CNT_W = $clog2(OVERSAMPLE_RATE);

  logic [CNT_W-1:0]      tick_cnt;
  logic                  hold_full;
  logic [DAC_BITLEN-1:0] hold;
  logic [DAC_BITLEN-1:0] cur;
  logic                  accept;
  logic                  tick;

  assign dac_ready = !hold_full;
  assign accept    = dac_valid && dac_ready;
  assign tick      = (tick_cnt == CNT_W'(OVERSAMPLE_RATE - 1));

  // Accept can only coincide with a tick when hold is empty, so the two updates never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt     <= '0;
      hold_full    <= 1'b0;
      hold         <= '0;
      cur          <= '0;
      dac_underrun <= 1'b0;
      sample_tick  <= 1'b0;
    end else begin
      tick_cnt     <= tick_cnt + CNT_W'(1);
      sample_tick  <= tick;
      dac_underrun <= tick && !hold_full;
      if (tick && hold_full) begin
        cur       <= hold;
        hold_full <= 1'b0;
      end
      if (accept) begin
        hold      <= dac_input;
        hold_full <= 1'b1;
      end
    end
  end

  sigma_delta_dac_modulator #(
    .DAC_BITLEN(DAC_BITLEN),
    .MOD_ORDER (MOD_ORDER)
  ) u_mod (
    .clk    (clk),
    .rst    (rst),
    .cur    (cur),
    .dac_pin(dac_pin)
  );

endmodule
